// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
//  - FWD_RF    : fwd_sel code meaning "take the operand from the register file"
//  - sel_width : width of a fwd_sel field for a given scoreboard depth
package fwd_pkg;

    localparam int FWD_RF = 0;

    // Codes 0..DEPTH must fit: 0 = regfile, k+1 = scoreboard entry k.
    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority encoder over the in-flight writer scoreboard.
// Finds the youngest (lowest index) valid entry whose destination equals src.
// Ports:
//  src      in   AW          register being looked up (r0 never matches)
//  ent_vld  in   DEPTH       entry valid bits, bit k = entry k
//  ent_load in   DEPTH       entry is a load
//  ent_rd   in   DEPTH*AW    entry destinations, entry k at [k*AW +: AW]
//  hit      out  1           some entry matched
//  sel      out  SELW        k+1 of the youngest match, FWD_RF on no match
//  is_load  out  1           youngest match is a load
module fwd_match
    import fwd_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 2,
    parameter int SELW  = 2
) (
    input  logic [AW-1:0]       src,
    input  logic [DEPTH-1:0]    ent_vld,
    input  logic [DEPTH-1:0]    ent_load,
    input  logic [DEPTH*AW-1:0] ent_rd,
    output logic                hit,
    output logic [SELW-1:0]     sel,
    output logic                is_load
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit     = 1'b0;
        sel     = SELW'(FWD_RF);
        is_load = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((src != '0) && ent_vld[k] && (ent_rd[k*AW +: AW] == src)) begin
                hit     = 1'b1;
                sel     = SELW'(k + 1);
                is_load = ent_load[k];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard unit for the pipelined MIPS core.
// Keeps a DEPTH-entry shift register of in-flight register writers fed from EX,
// picks the youngest forwarding source for each EX operand, and stalls ID when a
// consumer needs load data that cannot be forwarded yet.
// Ports:
//  clk, rst          clock (rising edge), asynchronous active-high reset
//  ex_valid/regwrite/memread/rd/src   instruction currently in EX
//  id_valid, id_src  instruction currently in ID
//  flush             squash the EX instruction this cycle
//  fwd_en, fwd_sel   per EX operand: forward enable and source (0 = regfile, k+1 = entry k)
//  stall             hold PC/IF/ID and bubble EX next cycle
//  stall_cnt         saturating count of stalled cycles
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int AW       = 5,
    parameter  int NSRC     = 2,
    parameter  int DEPTH    = 2,
    parameter  int LOAD_LAT = 1,
    parameter  int CNTW     = 16,
    localparam int SELW     = sel_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic [AW-1:0]        ex_rd,
    input  logic [NSRC*AW-1:0]   ex_src,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic                 flush,
    output logic [NSRC-1:0]      fwd_en,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall,
    output logic [CNTW-1:0]      stall_cnt
);

    // Scoreboard: entry 0 = M, 1 = WB, higher = late writeback.
    logic [DEPTH-1:0]    vld_q,  vld_d;
    logic [DEPTH-1:0]    load_q, load_d;
    logic [DEPTH*AW-1:0] rd_q,   rd_d;
    logic [CNTW-1:0]     cnt_q,  cnt_d;

    logic                ex_rec;
    logic [NSRC-1:0]     ex_hit;
    logic [NSRC-1:0]     ex_load_unused;
    logic [SELW-1:0]     ex_sel [NSRC];
    logic [NSRC-1:0]     id_hit;
    logic [NSRC-1:0]     id_load;
    logic [SELW-1:0]     id_sel [NSRC];
    logic [NSRC-1:0]     haz_ex;
    logic [NSRC-1:0]     haz_sb;

    // Writes to r0 and squashed instructions never enter the scoreboard.
    assign ex_rec = ex_valid & ex_regwrite & (ex_rd != '0) & ~flush;

    always_comb begin
        vld_d  = '0;
        load_d = '0;
        rd_d   = '0;
        vld_d[0]       = ex_rec;
        load_d[0]      = ex_memread;
        rd_d[AW-1:0]   = ex_rd;
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k]           = vld_q[k-1];
            load_d[k]          = load_q[k-1];
            rd_d[k*AW +: AW]   = rd_q[(k-1)*AW +: AW];
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_match #(
            .AW    (AW),
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_ex_match (
            .src      (ex_src[i*AW +: AW]),
            .ent_vld  (vld_q),
            .ent_load (load_q),
            .ent_rd   (rd_q),
            .hit      (ex_hit[i]),
            .sel      (ex_sel[i]),
            .is_load  (ex_load_unused[i])
        );

        fwd_match #(
            .AW    (AW),
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_id_match (
            .src      (id_src[i*AW +: AW]),
            .ent_vld  (vld_q),
            .ent_load (load_q),
            .ent_rd   (rd_q),
            .hit      (id_hit[i]),
            .sel      (id_sel[i]),
            .is_load  (id_load[i])
        );

        assign fwd_en[i]                = ex_hit[i];
        assign fwd_sel[i*SELW +: SELW]  = ex_sel[i];

        // Load sitting in EX right now: its data is never forwardable to the next EX.
        assign haz_ex[i] = ex_valid & ex_regwrite & ex_memread &
                           (id_src[i*AW +: AW] != '0) & (ex_rd == id_src[i*AW +: AW]);

        // Youngest match is a load that still needs more entries before forwarding.
        // A younger non-load match hides the older load, so only the youngest counts.
        assign haz_sb[i] = id_hit[i] & id_load[i] & (int'(id_sel[i]) < LOAD_LAT);
    end

    // rst gates the combinational EX term too, so stall is quiet during reset.
    assign stall = ~rst & id_valid & ~flush & (|(haz_ex | haz_sb));

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload fields are qualified by vld_q and need no reset.
    always_ff @(posedge clk) begin
        load_q <= load_d;
        rd_q   <= rd_d;
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_regwrite = 1'b0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [9:0]  ex_src = '0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_src = '0;
    logic        flush = 1'b0;

    logic [1:0]  a_en, b_en;
    logic [3:0]  a_sel, b_sel;
    logic        a_stall, b_stall;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    logic        use_b = 1'b0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [1:0]  en;
        logic [3:0]  sel;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .AW(5), .NSRC(2), .DEPTH(2), .LOAD_LAT(1), .CNTW(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_src(ex_src), .id_valid(id_valid),
        .id_src(id_src), .flush(flush), .fwd_en(a_en), .fwd_sel(a_sel),
        .stall(a_stall), .stall_cnt(a_cnt)
    );

    fwd_hazard_unit #(
        .AW(5), .NSRC(2), .DEPTH(3), .LOAD_LAT(2), .CNTW(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_src(ex_src), .id_valid(id_valid),
        .id_src(id_src), .flush(flush), .fwd_en(b_en), .fwd_sel(b_sel),
        .stall(b_stall), .stall_cnt(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, queue the expected outputs, compare on the falling edge.
    task automatic cyc(input string tag,
                       input logic ev, input logic rw, input logic mr, input logic [4:0] rd,
                       input logic [4:0] es0, input logic [4:0] es1,
                       input logic iv, input logic [4:0] is0, input logic [4:0] is1,
                       input logic fl,
                       input logic [1:0] en, input logic [3:0] sel, input logic st,
                       input logic [15:0] cnt);
        exp_t e;
        ex_valid    = ev;
        ex_regwrite = rw;
        ex_memread  = mr;
        ex_rd       = rd;
        ex_src      = {es1, es0};
        id_valid    = iv;
        id_src      = {is1, is0};
        flush       = fl;
        e.en = en; e.sel = sel; e.st = st; e.cnt = cnt;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            if (use_b) begin
                check_eq({tag, "_en"},    32'(b_en),    32'(e.en));
                check_eq({tag, "_sel"},   32'(b_sel),   32'(e.sel));
                check_eq({tag, "_stall"}, 32'(b_stall), 32'(e.st));
                check_eq({tag, "_cnt"},   32'(b_cnt),   32'(e.cnt));
            end else begin
                check_eq({tag, "_en"},    32'(a_en),    32'(e.en));
                check_eq({tag, "_sel"},   32'(a_sel),   32'(e.sel));
                check_eq({tag, "_stall"}, 32'(a_stall), 32'(e.st));
                check_eq({tag, "_cnt"},   32'(a_cnt),   32'(e.cnt));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // DEPTH=2, LOAD_LAT=1 instance
        use_b = 1'b0;
        rst = 1'b1;
        cyc("rst0", 1,1,1,5, 5,0, 1,5,0, 0,  2'd0, 4'h0, 0, 16'd0);
        rst = 1'b0;
        cyc("a1",  1,1,0,3, 0,0, 0,0,0, 0,  2'd0, 4'h0, 0, 16'd0);
        cyc("a2",  0,0,0,0, 3,0, 0,0,0, 0,  2'd1, 4'h1, 0, 16'd0);
        cyc("a3",  0,0,0,0, 3,3, 0,0,0, 0,  2'd3, 4'hA, 0, 16'd0);
        cyc("a4",  1,1,0,3, 3,0, 0,0,0, 0,  2'd0, 4'h0, 0, 16'd0);
        cyc("a5",  1,1,0,3, 0,3, 0,0,0, 0,  2'd2, 4'h4, 0, 16'd0);
        cyc("a6",  0,0,0,0, 3,0, 0,0,0, 0,  2'd1, 4'h1, 0, 16'd0);
        cyc("a7",  1,1,1,5, 3,0, 1,5,0, 0,  2'd1, 4'h2, 1, 16'd0);
        cyc("a8",  0,0,0,0, 5,0, 1,5,0, 0,  2'd1, 4'h1, 0, 16'd1);
        cyc("a9",  1,1,0,6, 5,0, 0,0,0, 0,  2'd1, 4'h2, 0, 16'd1);
        cyc("a10", 1,1,0,0, 0,6, 0,0,0, 0,  2'd2, 4'h4, 0, 16'd1);
        cyc("a11", 0,0,0,0, 0,0, 0,0,0, 0,  2'd0, 4'h0, 0, 16'd1);
        cyc("a12", 1,1,1,5, 0,0, 1,5,0, 1,  2'd0, 4'h0, 0, 16'd1);
        cyc("a13", 0,0,0,0, 5,0, 1,0,5, 0,  2'd0, 4'h0, 0, 16'd1);
        cyc("a14", 1,1,1,5, 0,0, 0,0,0, 0,  2'd0, 4'h0, 0, 16'd1);
        cyc("a15", 1,1,0,5, 0,0, 0,0,0, 0,  2'd0, 4'h0, 0, 16'd1);
        cyc("a16", 0,0,0,0, 5,0, 0,0,0, 0,  2'd1, 4'h1, 0, 16'd1);
        cyc("a17", 1,1,1,7, 0,0, 1,0,7, 0,  2'd0, 4'h0, 1, 16'd1);
        cyc("a18", 0,0,0,0, 7,0, 0,0,0, 0,  2'd1, 4'h1, 0, 16'd2);
        rst = 1'b1;
        cyc("a19", 1,1,1,7, 7,0, 1,0,7, 0,  2'd0, 4'h0, 0, 16'd0);
        rst = 1'b0;

        // DEPTH=3, LOAD_LAT=2, CNTW=2 instance
        use_b = 1'b1;
        cyc("b1",  1,1,1,5, 0,0, 1,5,0, 0,  2'd0, 4'h0, 1, 16'd0);
        cyc("b2",  0,0,0,0, 0,0, 1,5,0, 0,  2'd0, 4'h0, 1, 16'd1);
        cyc("b3",  0,0,0,0, 5,0, 1,5,0, 0,  2'd1, 4'h2, 0, 16'd2);
        cyc("b4",  1,1,0,6, 5,0, 0,0,0, 0,  2'd1, 4'h3, 0, 16'd2);
        cyc("b5",  1,1,1,8, 0,0, 0,0,0, 0,  2'd0, 4'h0, 0, 16'd2);
        cyc("b6",  1,1,0,8, 0,0, 0,0,0, 0,  2'd0, 4'h0, 0, 16'd2);
        cyc("b7",  0,0,0,0, 0,8, 1,0,8, 0,  2'd2, 4'h4, 0, 16'd2);
        cyc("b8",  1,1,1,9, 0,0, 1,9,0, 0,  2'd0, 4'h0, 1, 16'd2);
        cyc("b9",  0,0,0,0, 0,0, 1,9,0, 0,  2'd0, 4'h0, 1, 16'd3);
        cyc("b10", 1,1,1,9, 0,0, 1,9,0, 0,  2'd0, 4'h0, 1, 16'd3);
        cyc("b11", 0,0,0,0, 0,0, 0,0,0, 0,  2'd0, 4'h0, 0, 16'd3);
        cyc("b12", 1,1,1,9, 9,0, 1,9,0, 1,  2'd1, 4'h2, 0, 16'd3);

        if (exp_q.size() != 0) begin
            check_eq("queue_drain", 32'(exp_q.size()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
